gain_sweep_ctrl: RTL and testbench

Sequencer for the op-amp DC/AC gain characterisation path. It steps the programmable bias-current DAC (the Idc source feeding the amplifier) through a sweep. After each DAC load it waits a settling interval, then requests 2^AVG_LOG2 ADC conversions of the amplifier output via a req/ack handshake. It averages the conversions and reports one result per bias point. It sits between the test-register block and the analog DAC/ADC interface.

---
 rtl/gain_sweep_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_gain_sweep_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_sweep_ctrl.sv
// Bias-DAC sweep sequencer: load code, settle, average 2^AVG_LOG2 ADC samples,
// report one result per point; stops early if the next code would overflow.
`timescale 1ns/1ps
module gain_sweep_ctrl #(
  parameter int unsigned DAC_W    = 8,
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned SETTLE_W = 16,
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DAC_W-1:0]    dac_start,
  input  logic [DAC_W-1:0]    dac_step,
  input  logic [STEP_W-1:0]   n_points,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  output logic [DAC_W-1:0]    res_code,
  output logic [ADC_W-1:0]    res_data,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int unsigned AccW = ADC_W + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] LastSmp = CntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSettle, StSample, StReport, StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [DAC_W-1:0]    code_q, code_d, step_q, step_d;
  logic [STEP_W-1:0]   npts_q, npts_d, pt_q, pt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d, scnt_q, scnt_d;
  logic [AccW-1:0]     acc_q, acc_d, acc_sum;
  logic [CntW-1:0]     smp_q, smp_d;
  logic                gap_q, gap_d, park_q, park_d, ovf_q, ovf_d;
  logic [DAC_W-1:0]    rcode_q, rcode_d;
  logic [ADC_W-1:0]    rdata_q, rdata_d;
  logic [DAC_W:0]      next_code;

  assign next_code = {1'b0, code_q} + {1'b0, step_q};
  assign acc_sum   = acc_q + AccW'(adc_data);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    step_d   = step_q;
    npts_d   = npts_q;
    pt_d     = pt_q;
    settle_d = settle_q;
    scnt_d   = scnt_q;
    acc_d    = acc_q;
    smp_d    = smp_q;
    gap_d    = gap_q;
    park_d   = 1'b0;
    ovf_d    = ovf_q;
    rcode_d  = rcode_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StLoad;
          code_d   = dac_start;
          step_d   = dac_step;
          npts_d   = (n_points == '0) ? STEP_W'(1) : n_points;
          settle_d = settle_cycles;
          pt_d     = '0;
          ovf_d    = 1'b0;
        end
      end
      StLoad: begin
        scnt_d  = '0;
        acc_d   = '0;
        smp_d   = '0;
        gap_d   = 1'b0;
        state_d = (settle_q == '0) ? StSample : StSettle;
      end
      StSettle: begin
        scnt_d = scnt_q + SETTLE_W'(1);
        if (scnt_q == settle_q - SETTLE_W'(1)) state_d = StSample;
      end
      StSample: begin
        // One idle cycle after every ack; acks seen with req low are dropped.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (adc_ack) begin
          acc_d = acc_sum;
          if (smp_q == LastSmp) begin
            state_d = StReport;
            rcode_d = code_q;
            rdata_d = ADC_W'(acc_sum >> AVG_LOG2);
          end else begin
            smp_d = smp_q + CntW'(1);
            gap_d = 1'b1;
          end
        end
      end
      StReport: begin
        pt_d = pt_q + STEP_W'(1);
        if (pt_q == npts_q - STEP_W'(1)) begin
          state_d = StFinish;
        end else if (next_code[DAC_W]) begin
          ovf_d   = 1'b1;
          state_d = StFinish;
        end else begin
          code_d  = next_code[DAC_W-1:0];
          state_d = StLoad;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort overrides everything in flight and parks the bias DAC at zero.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      code_d  = '0;
      park_d  = 1'b1;
      gap_d   = 1'b0;
      acc_d   = acc_q;
      smp_d   = smp_q;
      ovf_d   = ovf_q;
      rcode_d = rcode_q;
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      code_q   <= '0;
      step_q   <= '0;
      npts_q   <= '0;
      pt_q     <= '0;
      settle_q <= '0;
      scnt_q   <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      gap_q    <= 1'b0;
      park_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rcode_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      step_q   <= step_d;
      npts_q   <= npts_d;
      pt_q     <= pt_d;
      settle_q <= settle_d;
      scnt_q   <= scnt_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      gap_q    <= gap_d;
      park_q   <= park_d;
      ovf_q    <= ovf_d;
      rcode_q  <= rcode_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dac_code  = code_q;
  assign dac_load  = (state_q == StLoad) || park_q;
  assign adc_req   = (state_q == StSample) && !gap_q;
  assign res_valid = (state_q == StReport);
  assign res_code  = rcode_q;
  assign res_data  = rdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gain_sweep_ctrl.sv
// Bench for gain_sweep_ctrl: table of sweeps, randomized sweeps against a sweep
// model, and hand sequences for reset, abort and disturbance cases.
`timescale 1ns/1ps
module tb_gain_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start0 = 1'b0, abort = 1'b0;
  logic [7:0]  dac_start = '0, dac_step = '0, n_points = '0;
  logic [15:0] settle_cycles = '0;
  logic [7:0]  dac_code, res_code, dac_code0, res_code0;
  logic        dac_load, adc_req, res_valid, busy, done, ovf;
  logic        dac_load0, adc_req0, res_valid0, busy0, done0, ovf0;
  logic        adc_ack = 1'b0, adc_ack0 = 1'b0;
  logic [11:0] adc_data = '0, adc_data0 = '0, res_data, res_data0;

  gain_sweep_ctrl #(.AVG_LOG2(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dac_start(dac_start),
    .dac_step(dac_step), .n_points(n_points), .settle_cycles(settle_cycles),
    .dac_code(dac_code), .dac_load(dac_load), .adc_req(adc_req), .adc_ack(adc_ack),
    .adc_data(adc_data), .res_valid(res_valid), .res_code(res_code), .res_data(res_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  gain_sweep_ctrl #(.AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .dac_start(dac_start),
    .dac_step(dac_step), .n_points(n_points), .settle_cycles(settle_cycles),
    .dac_code(dac_code0), .dac_load(dac_load0), .adc_req(adc_req0), .adc_ack(adc_ack0),
    .adc_data(adc_data0), .res_valid(res_valid0), .res_code(res_code0),
    .res_data(res_data0), .busy(busy0), .done(done0), .ovf(ovf0)
  );

  always #5 clk = ~clk;

  int vecs = 0, miscmp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ADC responder: ack rsp_lat cycles after req is seen, optional junk acks while req low.
  int rsp_lat = 0;
  bit rsp_fixed = 1'b1, rsp_spur = 1'b0;
  initial begin
    int wcnt = 0, k = 0;
    forever begin
      @(posedge clk); #1;
      adc_ack = 1'b0;
      if (dac_load) k = 0;
      if (adc_req) begin
        if (wcnt >= rsp_lat) begin
          adc_ack  = 1'b1;
          adc_data = rsp_fixed ? 12'(100 + 2 * k) : 12'($urandom);
          k++;
          wcnt = 0;
        end else wcnt++;
      end else begin
        wcnt = 0;
        if (rsp_spur && $urandom_range(0, 1) == 1) begin
          adc_ack  = 1'b1;
          adc_data = 12'hFFF;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      adc_ack0  = adc_req0;
      adc_data0 = 12'hABC;
    end
  end

  // Monitor: collects what the DUT did, cleared when clr_req moves.
  int clr_req = 0;
  logic [7:0]  load_q[$], rc_q[$];
  logic [11:0] rd_q[$], smp_q[$];
  int gap_q[$];
  int done_cnt = 0, gap_err = 0;
  initial begin
    int clr_seen = 0, since_load = -1;
    bit req_prev = 1'b0, acc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_seen != clr_req) begin
        load_q.delete(); rc_q.delete(); rd_q.delete(); smp_q.delete(); gap_q.delete();
        done_cnt = 0; gap_err = 0; since_load = -1; acc_prev = 1'b0;
        clr_seen = clr_req;
      end
      if (dac_load) begin
        load_q.push_back(dac_code);
        since_load = 0;
      end else if (since_load >= 0) since_load++;
      if (adc_req && !req_prev && since_load >= 0) begin
        gap_q.push_back(since_load);
        since_load = -1;
      end
      if (acc_prev && adc_req) gap_err++;
      acc_prev = adc_req && adc_ack;
      if (adc_req && adc_ack) smp_q.push_back(adc_data);
      if (res_valid) begin
        rc_q.push_back(res_code);
        rd_q.push_back(res_data);
      end
      if (done) done_cnt++;
      req_prev = adc_req;
    end
  end

  // Sweep model: list of reported codes and the overflow flag.
  int exp_codes[$];
  bit exp_ovf;
  task automatic build_model(input logic [7:0] s, input logic [7:0] st, input logic [7:0] n);
    int c, npts;
    exp_codes.delete();
    exp_ovf = 1'b0;
    c = int'(s);
    npts = (n == 0) ? 1 : int'(n);
    for (int i = 0; i < npts; i++) begin
      exp_codes.push_back(c);
      if (i == npts - 1) break;
      if (c + int'(st) > 255) begin
        exp_ovf = 1'b1;
        break;
      end
      c += int'(st);
    end
  endtask

  bit ovf_at_done;

  task automatic run_sweep(input logic [7:0] s, input logic [7:0] st, input logic [7:0] n,
                           input logic [15:0] se, input int lat, input bit fixed,
                           input bit disturb);
    bit seen = 1'b0;
    int cyc = 0;
    logic [13:0] sum;
    @(posedge clk); #1;
    clr_req++;
    rsp_lat = lat; rsp_fixed = fixed; rsp_spur = disturb;
    dac_start = s; dac_step = st; n_points = n; settle_cycles = se;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ovf_at_done = ovf;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (disturb && busy) begin
          start = ($urandom_range(0, 2) == 0);
          dac_start = 8'($urandom); dac_step = 8'($urandom);
          n_points = 8'($urandom); settle_cycles = 16'($urandom_range(0, 9));
        end
      end
    end
    start = 1'b0;
    rsp_spur = 1'b0;
    chk("sweep_done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    build_model(s, st, n);
    chk("point_count", 32'(rc_q.size()), 32'(exp_codes.size()));
    chk("load_count", 32'(load_q.size()), 32'(exp_codes.size()));
    chk("sample_count", 32'(smp_q.size()), 32'(exp_codes.size() * 4));
    chk("ovf", 32'(ovf_at_done), 32'(exp_ovf));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("req_gap_after_ack", 32'(gap_err), 32'd0);
    for (int i = 0; i < exp_codes.size(); i++) begin
      if (i < rc_q.size()) chk("res_code", 32'(rc_q[i]), 32'(exp_codes[i]));
      if (i < load_q.size()) chk("load_code", 32'(load_q[i]), 32'(exp_codes[i]));
      if (i < gap_q.size()) chk("settle_gap", 32'(gap_q[i]), 32'(se) + 32'd1);
      if (i < rd_q.size() && smp_q.size() >= 4 * (i + 1)) begin
        sum = '0;
        for (int j = 0; j < 4; j++) sum += 14'(smp_q[4 * i + j]);
        chk("res_data", 32'(rd_q[i]), 32'(sum >> 2));
      end
    end
  endtask

  typedef struct {
    logic [7:0]  s, st, n;
    logic [15:0] se;
    int          lat;
    int          exp_pts;
    bit          exp_ovf;
    logic [7:0]  exp_last;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bit found;
    tbl[0] = '{8'd10,  8'd5,   8'd3, 16'd4, 2, 2 + 1, 1'b0, 8'd20};
    tbl[1] = '{8'd250, 8'd4,   8'd5, 16'd2, 1, 2, 1'b1, 8'd254};
    tbl[2] = '{8'd0,   8'd0,   8'd0, 16'd0, 0, 1, 1'b0, 8'd0};
    tbl[3] = '{8'd200, 8'd55,  8'd2, 16'd1, 3, 2, 1'b0, 8'd255};
    tbl[4] = '{8'd100, 8'd100, 8'd3, 16'd3, 1, 2, 1'b1, 8'd200};
    tbl[5] = '{8'd5,   8'd3,   8'd0, 16'd2, 2, 1, 1'b0, 8'd5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dac_code", 32'(dac_code), 32'd0);
    chk("rst_dac_load", 32'(dac_load), 32'd0);
    chk("rst_adc_req", 32'(adc_req), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #1 rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_sweep(tbl[t].s, tbl[t].st, tbl[t].n, tbl[t].se, tbl[t].lat, 1'b1, 1'b0);
      chk("tbl_points", 32'(rc_q.size()), 32'(tbl[t].exp_pts));
      chk("tbl_ovf", 32'(ovf_at_done), 32'(tbl[t].exp_ovf));
      if (rc_q.size() > 0) begin
        chk("tbl_last_code", 32'(rc_q[rc_q.size() - 1]), 32'(tbl[t].exp_last));
        chk("tbl_res_data", 32'(rd_q[0]), 32'd103);
      end
    end

    // Start pulses, config churn and junk acks during a sweep must not matter.
    run_sweep(8'd10, 8'd5, 8'd3, 16'd4, 2, 1'b1, 1'b1);
    for (int i = 0; i < rd_q.size(); i++) chk("disturbed_res_data", 32'(rd_q[i]), 32'd103);

    for (int r = 0; r < 8; r++)
      run_sweep(8'($urandom), 8'($urandom_range(0, 80)), 8'($urandom_range(0, 6)),
                16'($urandom_range(0, 5)), $urandom_range(0, 3), 1'b0, 1'b0);

    // Abort in the same cycle as the third ack of the first point.
    @(posedge clk); #1;
    clr_req++;
    rsp_lat = 2; rsp_fixed = 1'b1;
    dac_start = 8'd10; dac_step = 8'd5; n_points = 8'd3; settle_cycles = 16'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk); #2;
      if (adc_req && adc_ack && smp_q.size() == 2) begin
        abort = 1'b1;
        found = 1'b1;
      end
    end
    chk("abort_third_ack_reached", 32'(found), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dac_load", 32'(dac_load), 32'd1);
    chk("abort_dac_code", 32'(dac_code), 32'd0);
    chk("abort_adc_req", 32'(adc_req), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_load_one_cycle", 32'(dac_load), 32'd0);
    chk("abort_no_res", 32'(rc_q.size()), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_sweep(8'd10, 8'd5, 8'd3, 16'd4, 2, 1'b1, 1'b0);

    // Asynchronous reset while a second-point request is pending.
    @(posedge clk); #1;
    clr_req++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (rc_q.size() == 1 && adc_req) found = 1'b1;
    end
    chk("reset_point_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac_code", 32'(dac_code), 32'd0);
    chk("arst_dac_load", 32'(dac_load), 32'd0);
    chk("arst_adc_req", 32'(adc_req), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_code", 32'(res_code), 32'd0);
    chk("arst_res_data", 32'(res_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    clr_req++;
    repeat (20) @(negedge clk);
    chk("arst_no_res_after", 32'(rc_q.size()), 32'd0);
    chk("arst_no_load_after", 32'(load_q.size()), 32'd0);
    chk("arst_idle_after", 32'(busy), 32'd0);

    // Single-sample instance: settle 0, n_points 0.
    @(posedge clk); #1;
    dac_start = 8'd33; dac_step = 8'd1; n_points = 8'd0; settle_cycles = 16'd0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(negedge clk);
    chk("s0_load", 32'(dac_load0), 32'd1);
    chk("s0_load_code", 32'(dac_code0), 32'd33);
    chk("s0_req_during_load", 32'(adc_req0), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("s0_req_after_load", 32'(adc_req0), 32'd1);
    chk("s0_load_off", 32'(dac_load0), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("s0_res_valid", 32'(res_valid0), 32'd1);
    chk("s0_res_code", 32'(res_code0), 32'd33);
    chk("s0_res_data", 32'(res_data0), 32'hABC);
    @(posedge clk); @(negedge clk);
    chk("s0_done", 32'(done0), 32'd1);
    chk("s0_single_res", 32'(res_valid0), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("s0_idle", 32'(busy0), 32'd0);
    chk("s0_ovf", 32'(ovf0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
